// File: rtl/fpu_sp_issue_queue_if.sv
// fpu_sp_issue_queue_if
//   Bundles the three buses of the FPU issue queue:
//     req_*  : request push side (valid/ready, operands, opcode, tag)
//     fpu_*  : single-operation port towards the FPU (dval/rdy)
//     rsp_*  : response side (valid/ready, result, tag, error)
//     q_level: request FIFO occupancy
//   Modports:
//     slave  : the issue queue itself
//     master : the environment (requester, FPU and response sink)
interface fpu_sp_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_din1;
  logic [31:0]      req_din2;
  logic [3:0]       req_cmd;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      fpu_din1;
  logic [31:0]      fpu_din2;
  logic [3:0]       fpu_cmd;
  logic             fpu_dval;
  logic [31:0]      fpu_result;
  logic             fpu_rdy;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic [LVL_W-1:0] q_level;

  modport slave (
    input  req_valid, req_din1, req_din2, req_cmd, req_tag,
    output req_ready,
    output fpu_din1, fpu_din2, fpu_cmd, fpu_dval,
    input  fpu_result, fpu_rdy,
    output rsp_valid, rsp_result, rsp_tag, rsp_err,
    input  rsp_ready,
    output q_level
  );

  modport master (
    output req_valid, req_din1, req_din2, req_cmd, req_tag,
    input  req_ready,
    input  fpu_din1, fpu_din2, fpu_cmd, fpu_dval,
    output fpu_result, fpu_rdy,
    input  rsp_valid, rsp_result, rsp_tag, rsp_err,
    output rsp_ready,
    input  q_level
  );
endinterface

// File: rtl/fpu_sp_issue_queue.sv
// fpu_sp_issue_queue
//   Request FIFO plus a 3-state sequencer in front of the single-precision
//   FPU. Requests are queued, issued one at a time on the FPU port, and each
//   accepted request produces exactly one response: the FPU result, or a
//   quiet NaN with err=1 for an illegal opcode or a watchdog timeout.
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous active-high reset
//     io  : fpu_sp_issue_queue_if.slave (req_*, fpu_*, rsp_*, q_level)
//   Parameters:
//     DEPTH   : FIFO entries, power of two, >= 2
//     TAG_W   : request tag width
//     TIMEOUT : cycles in ISSUE without fpu_rdy before aborting, >= 2
module fpu_sp_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
)(
  input logic               clk,
  input logic               rst,
  fpu_sp_issue_queue_if.slave io
);
  localparam int          AW    = $clog2(DEPTH);
  localparam int          LVL_W = AW + 1;
  localparam int          WD_W  = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [31:0]      din1;
    logic [31:0]      din2;
    logic [3:0]       cmd;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // ---------------------------------------------------------------- FIFO
  req_t [DEPTH-1:0] fifo_mem;
  req_t             wr_ent;
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push, pop;

  assign wr_ent.din1 = io.req_din1;
  assign wr_ent.din2 = io.req_din2;
  assign wr_ent.cmd  = io.req_cmd;
  assign wr_ent.tag  = io.req_tag;
  assign head        = fifo_mem[rd_ptr];

  // Ready depends only on occupancy: a full queue refuses even while popping.
  assign io.req_ready = (count != LVL_W'(DEPTH));
  assign push         = io.req_valid && io.req_ready;
  assign io.q_level   = count;

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_ent;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- FSM
  state_t          state_q, state_d;
  req_t            iss_q;
  logic [WD_W-1:0] wd_q;
  logic [31:0]     res_q;
  logic            err_q;
  logic            wd_clr, wd_inc, ld_ok, ld_err;

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd5);
  endfunction

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    ld_ok   = 1'b0;
    ld_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          // Illegal opcodes never reach the FPU; they answer directly.
          if (cmd_legal(head.cmd)) begin
            state_d = ISSUE;
            wd_clr  = 1'b1;
          end else begin
            state_d = RESP;
            ld_err  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (io.fpu_rdy) begin
          ld_ok   = 1'b1;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          ld_err  = 1'b1;
          state_d = RESP;
        end else begin
          wd_inc  = 1'b1;
        end
      end
      RESP: begin
        if (io.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iss_q   <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) iss_q <= head;
      if (wd_clr)      wd_q <= '0;
      else if (wd_inc) wd_q <= wd_q + 1'b1;
      // fpu_rdy is only honoured in ISSUE, so a late completion after a
      // timeout cannot overwrite a held or future response.
      if (ld_ok) begin
        res_q <= io.fpu_result;
        err_q <= 1'b0;
      end else if (ld_err) begin
        res_q <= QNAN;
        err_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  // Operands come straight from the issue register, stable for the whole
  // ISSUE state. dval low in IDLE and RESP guarantees a >=2 cycle gap.
  assign io.fpu_dval   = (state_q == ISSUE);
  assign io.fpu_din1   = iss_q.din1;
  assign io.fpu_din2   = iss_q.din2;
  assign io.fpu_cmd    = iss_q.cmd;
  assign io.rsp_valid  = (state_q == RESP);
  assign io.rsp_result = res_q;
  assign io.rsp_tag    = iss_q.tag;
  assign io.rsp_err    = err_q;
endmodule

// File: tb/tb_fpu_sp_issue_queue.sv
module tb_fpu_sp_issue_queue;
  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 8;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] OPA  = 32'h41400000;  // 12.0
  localparam logic [31:0] OPB  = 32'h40C00000;  // 6.0

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_sp_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc();

  fpu_sp_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------ FPU stub
  int stub_lat   = 3;
  bit stub_never = 1'b0;
  bit stray_rdy  = 1'b0;
  int stub_cnt;

  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    if (a == OPA && b == OPB) begin
      case (c)
        4'd1: return 32'h41900000;
        4'd2: return 32'h40C00000;
        4'd3: return 32'h42900000;
        4'd4: return 32'h40000000;
        4'd5: return 32'h405DB3D7;
        default: ;
      endcase
    end
    return 32'h3F800000 ^ a ^ {b[15:0], b[31:16]} ^ {28'd0, c};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) stub_cnt <= 0;
    else     stub_cnt <= ifc.fpu_dval ? stub_cnt + 1 : 0;

  assign ifc.fpu_rdy    = (ifc.fpu_dval && !stub_never && stub_cnt == stub_lat) || stray_rdy;
  assign ifc.fpu_result = fpu_model(ifc.fpu_din1, ifc.fpu_din2, ifc.fpu_cmd);

  // ------------------------------------------------------- dval monitor
  int          dval_rises = 0;
  int          low_run    = 0;
  int          min_gap    = 1000;
  int          stab_err   = 0;
  bit          mon_seen   = 1'b0;
  logic        mon_prev   = 1'b0;
  logic [67:0] mon_ops    = '0;
  logic [67:0] last_ops   = '0;

  always @(negedge clk) begin
    mon_prev <= ifc.fpu_dval;
    mon_ops  <= {ifc.fpu_din1, ifc.fpu_din2, ifc.fpu_cmd};
    if (ifc.fpu_dval && !mon_prev) begin
      dval_rises <= dval_rises + 1;
      if (mon_seen && low_run < min_gap) min_gap <= low_run;
      mon_seen <= 1'b1;
      last_ops <= {ifc.fpu_din1, ifc.fpu_din2, ifc.fpu_cmd};
    end
    if (ifc.fpu_dval && mon_prev && ({ifc.fpu_din1, ifc.fpu_din2, ifc.fpu_cmd} != mon_ops))
      stab_err <= stab_err + 1;
    low_run <= ifc.fpu_dval ? 0 : low_run + 1;
  end

  // -------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Caller must be just after a negedge; returns just after a negedge.
  task automatic push(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [3:0] c, input logic [TAG_W-1:0] t);
    int n = 0;
    ifc.req_din1  = d1;
    ifc.req_din2  = d2;
    ifc.req_cmd   = c;
    ifc.req_tag   = t;
    ifc.req_valid = 1'b1;
    while (!ifc.req_ready && n < 500) begin @(negedge clk); n++; end
    chk("push_accept", 32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!ifc.rsp_valid && n < 500) begin @(negedge clk); n++; end
  endtask

  task automatic rx_check(input string name, input logic [31:0] r,
                          input logic [TAG_W-1:0] t, input logic e);
    int n;
    wait_rsp(n);
    chk($sformatf("%s_valid", name), 32'(ifc.rsp_valid), 32'd1);
    chk($sformatf("%s_res", name), ifc.rsp_result, r);
    chk($sformatf("%s_tag", name), 32'(ifc.rsp_tag), 32'(t));
    chk($sformatf("%s_err", name), 32'(ifc.rsp_err), 32'(e));
    @(negedge clk);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_req_ready"}, 32'(ifc.req_ready), 32'd1);
    chk({p, "_q_level"},   32'(ifc.q_level),   32'd0);
    chk({p, "_dval"},      32'(ifc.fpu_dval),  32'd0);
    chk({p, "_rsp_valid"}, 32'(ifc.rsp_valid), 32'd0);
    chk({p, "_din1"},      ifc.fpu_din1,       32'd0);
    chk({p, "_din2"},      ifc.fpu_din2,       32'd0);
    chk({p, "_cmd"},       32'(ifc.fpu_cmd),   32'd0);
    chk({p, "_result"},    ifc.rsp_result,     32'd0);
    chk({p, "_tag"},       32'(ifc.rsp_tag),   32'd0);
    chk({p, "_err"},       32'(ifc.rsp_err),   32'd0);
  endtask

  // --------------------------------------------------------------- table
  typedef struct {
    logic [31:0]      d1;
    logic [31:0]      d2;
    logic [3:0]       cmd;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_res;
    logic             exp_err;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  localparam logic [31:0] RES_BY_CMD [5] =
    '{32'h41900000, 32'h40C00000, 32'h42900000, 32'h40000000, 32'h405DB3D7};

  initial begin
    int k, r0, extra;

    vec[0] = '{OPA, OPB, 4'd1, 4'd1, 32'h41900000, 1'b0};
    vec[1] = '{OPA, OPB, 4'd2, 4'd2, 32'h40C00000, 1'b0};
    vec[2] = '{OPA, OPB, 4'd3, 4'd3, 32'h42900000, 1'b0};
    vec[3] = '{OPA, OPB, 4'd4, 4'd4, 32'h40000000, 1'b0};
    vec[4] = '{OPA, OPB, 4'd5, 4'd5, 32'h405DB3D7, 1'b0};
    vec[5] = '{OPA, OPB, 4'hA, 4'd6, QNAN,         1'b1};
    vec[6] = '{OPA, OPB, 4'h0, 4'd7, QNAN,         1'b1};
    vec[7] = '{OPA, OPB, 4'hF, 4'd8, QNAN,         1'b1};
    vec[8] = '{OPA, OPB, 4'd3, 4'd9, 32'h42900000, 1'b0};

    ifc.req_valid = 1'b0;
    ifc.req_din1  = '0;
    ifc.req_din2  = '0;
    ifc.req_cmd   = '0;
    ifc.req_tag   = '0;
    ifc.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single add, L=3: latency counted in edges from the push edge inclusive
    r0 = dval_rises;
    ifc.req_din1 = OPA; ifc.req_din2 = OPB; ifc.req_cmd = 4'd1; ifc.req_tag = 4'd5;
    ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    wait_rsp(k);
    chk("add_latency", 32'(1 + k), 32'(stub_lat + 3));
    chk("add_res", ifc.rsp_result, 32'h41900000);
    chk("add_tag", 32'(ifc.rsp_tag), 32'd5);
    chk("add_err", 32'(ifc.rsp_err), 32'd0);
    chk("add_op_a", last_ops[67:36], OPA);
    chk("add_op_b", last_ops[35:4], OPB);
    chk("add_op_cmd", 32'(last_ops[3:0]), 32'd1);
    @(negedge clk);
    chk("add_consumed", 32'(ifc.rsp_valid), 32'd0);
    chk("add_dval_rises", 32'(dval_rises - r0), 32'd1);

    // Table: back-to-back pushes with a concurrent in-order receiver
    r0 = dval_rises;
    fork
      begin
        for (int i = 0; i < NV; i++) push(vec[i].d1, vec[i].d2, vec[i].cmd, vec[i].tag);
      end
      begin
        for (int j = 0; j < NV; j++)
          rx_check($sformatf("tbl%0d", j), vec[j].exp_res, vec[j].tag, vec[j].exp_err);
      end
    join
    chk("tbl_dval_rises", 32'(dval_rises - r0), 32'd6);
    chk("tbl_min_gap_ge2", 32'(min_gap >= 2), 32'd1);
    chk("tbl_dval_stable", 32'(stab_err), 32'd0);

    // Illegal cmd: response one edge after the pop, no FPU traffic
    r0 = dval_rises;
    ifc.req_din1 = OPA; ifc.req_din2 = OPB; ifc.req_cmd = 4'hA; ifc.req_tag = 4'd3;
    ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    wait_rsp(k);
    chk("ill_latency", 32'(1 + k), 32'd2);
    chk("ill_res", ifc.rsp_result, QNAN);
    chk("ill_err", 32'(ifc.rsp_err), 32'd1);
    chk("ill_tag", 32'(ifc.rsp_tag), 32'd3);
    @(negedge clk);
    chk("ill_no_dval", 32'(dval_rises - r0), 32'd0);

    // Backpressure / full
    ifc.rsp_ready = 1'b0;
    push(OPA, OPB, 4'd1, 4'd0);
    repeat (2) @(negedge clk);
    chk("bp_first_pop", 32'(ifc.q_level), 32'd0);
    for (int i = 1; i < 5; i++) push(OPA, OPB, 4'(i + 1), 4'(i));
    chk("bp_full_level", 32'(ifc.q_level), 32'd4);
    chk("bp_full_ready", 32'(ifc.req_ready), 32'd0);
    chk("bp_in_resp", 32'(ifc.rsp_valid), 32'd1);
    chk("bp_held_tag", 32'(ifc.rsp_tag), 32'd0);
    ifc.req_din1 = OPA; ifc.req_din2 = OPB; ifc.req_cmd = 4'd1; ifc.req_tag = 4'd6;
    ifc.req_valid = 1'b1;
    @(negedge clk);
    chk("bp_refused_level", 32'(ifc.q_level), 32'd4);
    chk("bp_held_res", ifc.rsp_result, 32'h41900000);
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      rx_check($sformatf("bp%0d", i), RES_BY_CMD[i], 4'(i), 1'b0);
    extra = 0;
    repeat (10) begin @(negedge clk); if (ifc.rsp_valid) extra++; end
    chk("bp_no_extra", 32'(extra), 32'd0);
    chk("bp_drained", 32'(ifc.q_level), 32'd0);

    // Timeout, then a stray rdy, then a normal request
    stub_never = 1'b1;
    ifc.req_din1 = OPA; ifc.req_din2 = OPB; ifc.req_cmd = 4'd1; ifc.req_tag = 4'd9;
    ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    wait_rsp(k);
    chk("to_latency", 32'(1 + k), 32'(TIMEOUT + 2));
    chk("to_res", ifc.rsp_result, QNAN);
    chk("to_err", 32'(ifc.rsp_err), 32'd1);
    chk("to_tag", 32'(ifc.rsp_tag), 32'd9);
    @(negedge clk);
    repeat (2) @(negedge clk);
    stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    extra = 0;
    repeat (10) begin @(negedge clk); if (ifc.rsp_valid) extra++; end
    chk("to_stray_ignored", 32'(extra), 32'd0);
    stub_never = 1'b0;
    push(OPA, OPB, 4'd3, 4'd10);
    rx_check("to_next", 32'h42900000, 4'd10, 1'b0);

    // Reset mid-ISSUE with two entries queued
    stub_never = 1'b1;
    push(OPA, OPB, 4'd1, 4'd11);
    push(OPA, OPB, 4'd2, 4'd12);
    push(OPA, OPB, 4'd3, 4'd13);
    chk("mid_level", 32'(ifc.q_level), 32'd2);
    chk("mid_dval", 32'(ifc.fpu_dval), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    stub_never = 1'b0;
    r0 = dval_rises;
    extra = 0;
    repeat (20) begin @(negedge clk); if (ifc.rsp_valid) extra++; end
    chk("post_rst_no_rsp", 32'(extra), 32'd0);
    chk("post_rst_no_dval", 32'(dval_rises - r0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/fpu_sp_issue_queue.md
# fpu_sp_issue_queue

Request buffer and command sequencer that sits directly upstream of the single-precision FPU top. It accepts operand/command requests over a valid/ready interface into a FIFO and issues them one at a time on the FPU's `din1/din2/cmd/dval` port. It waits for `rdy`, then returns the result, tag and error flag over a valid/ready response interface. A watchdog and an illegal-command check ensure every accepted request gets exactly one response.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `TAG_W`, 4: request tag width, echoed in the response.
- `TIMEOUT`, 64: cycles to wait for `fpu_rdy` before aborting (≥2).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_din1` in 32: operand A, IEEE-754 single.
- `req_din2` in 32: operand B.
- `req_cmd` in 4: opcode. 1=add, 2=sub, 3=mul, 4=div, 5=sqrt(din1). Any other value is illegal.
- `req_tag` in TAG_W: request tag.
- `fpu_din1` out 32, `fpu_din2` out 32, `fpu_cmd` out 4: operands/opcode to the FPU, held stable while `fpu_dval`=1.
- `fpu_dval` out 1: operation request to the FPU.
- `fpu_result` in 32: FPU result, valid in a cycle with `fpu_rdy`=1.
- `fpu_rdy` in 1: FPU completion.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out 32, `rsp_tag` out TAG_W, `rsp_err` out 1: response payload.
- `q_level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs when `req_valid && req_ready`.
  - `req_ready = (q_level != DEPTH)`. There is no same-cycle pass-through, so a full FIFO refuses a request even in a cycle where it pops.
  - Simultaneous push and pop leaves `q_level` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE**
  - If `q_level != 0`, pop the head into the issue registers.
  - If the popped cmd is 1–5, go to ISSUE and clear the watchdog.
  - Otherwise load `rsp_result=32'h7FC00000`, `rsp_err=1` and go to RESP; nothing is sent to the FPU.
- **ISSUE**
  - `fpu_dval=1`, with `fpu_din1/din2/cmd` taken from the issue registers.
  - If `fpu_rdy`=1: capture `fpu_result` into `rsp_result`, set `rsp_err=0`, go to RESP.
  - Else, if the watchdog equals TIMEOUT-1: set `rsp_result=32'h7FC00000`, `rsp_err=1`, go to RESP.
  - Otherwise increment the watchdog.
- **RESP**
  - `rsp_valid=1`; the payload is held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- `fpu_dval` is 0 in IDLE and RESP. The FPU therefore sees dval low for at least 2 cycles between operations.
- `fpu_rdy` outside ISSUE is ignored. This covers a late completion after a timeout.
- **Reset (asynchronous, at any time, including mid-operation):**
  - FIFO is emptied and `q_level=0`; the FSM goes to IDLE.
  - Outputs: `fpu_dval=0`, `rsp_valid=0`, `fpu_din1/din2=0`, `fpu_cmd=0`, `rsp_result=0`, `rsp_tag=0`, `rsp_err=0`, `req_ready=1` after reset.
  - Queued and in-flight requests are discarded without a response.

## Timing
- Requests complete strictly in order, one in flight at a time.
- **Latency** (empty queue, FSM in IDLE, FPU rdy L cycles after dval rises, `rsp_ready` tied high):
  - Push at edge E0.
  - Pop at E1; `fpu_dval` high after E1.
  - `fpu_rdy` in cycle E1+L; `rsp_valid` high after edge E1+L+1.
  - Response accepted at E1+L+2.
- Illegal cmd: pop at E1, `rsp_valid` high after E1.
- Timeout: `rsp_valid` rises TIMEOUT+1 edges after the pop if `fpu_rdy` never arrives.
- **Throughput:** one operation per L+3 cycles.
- **Backpressure:** with `rsp_ready`=0, the FSM stays in RESP while the FIFO keeps accepting until full.

## Test plan
Benches use a behavioural FPU stub with programmable latency L.
- **Single add, L=3:** push din1=41400000, din2=40C00000, cmd=1, tag=5.
  - Response result=41900000, tag=5, err=0.
  - Exactly 1 `fpu_dval` rising edge; latency = L+3 edges from push to `rsp_valid`.
- **Back-to-back cmds 1–5** with the same operands (the sqrt operand is din1 = 12.0):
  - Results in order: 41900000, 40C00000, 42900000, 40000000, 405DB3D7.
  - `fpu_dval` drops ≥2 cycles between operations; tags are echoed.
- **Full/backpressure, DEPTH=4, `rsp_ready`=0:**
  - After the first pop, 4 more pushes leave `q_level`=4 and `req_ready`=0; a 6th push is refused.
  - Release `rsp_ready`: all 5 responses return in order and `q_level` returns to 0.
- **Illegal cmd=4'hA:**
  - No `fpu_dval` pulse.
  - Response 7FC00000, err=1, within 2 cycles of the pop.
- **Timeout, stub never asserts rdy, TIMEOUT=8:**
  - err=1, result 7FC00000.
  - A stray `fpu_rdy` 3 cycles later produces no response; the next request completes normally.
- **Reset mid-ISSUE with 2 entries queued:**
  - All outputs reach their reset values asynchronously; `q_level=0`.
  - No response is produced for the discarded requests.
